// File: rtl/grid_sweep_controller.sv
// Raster sweep sequencer: per-cell view -> settle -> write handshake, run/pause gating, overrun detection.
// Optional macro SWEEP_SINGLE_STEP_EN adds STEP_KEY_N for one-sweep stepping while paused.
module grid_sweep_controller #(
    parameter int X_bits = 8,
    parameter int Y_bits = 8,
    parameter int X_MAX  = 160,
    parameter int Y_MAX  = 120
) (
    input  logic              newLocClock,
    input  logic              RESET_SIM_N,
    input  logic              RUN,
    input  logic              game_clk,
    input  logic              KEY_PAUSE,
`ifdef SWEEP_SINGLE_STEP_EN
    input  logic              STEP_KEY_N,
`endif
    input  logic              view_ack,
    output logic [X_bits-1:0] writeLoc_x,
    output logic [Y_bits-1:0] writeLoc_y,
    output logic              view_req,
    output logic              write_flag,
    output logic              hold_locs,
    output logic              sweep_busy,
    output logic              sweep_done,
    output logic              paused,
    output logic              overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_WRITE,
        S_ADVANCE
    } state_t;

    localparam logic [X_bits-1:0] X_LAST = X_bits'(X_MAX - 1);
    localparam logic [Y_bits-1:0] Y_LAST = Y_bits'(Y_MAX - 1);

    state_t            state, state_next;
    logic [X_bits-1:0] x_next;
    logic [Y_bits-1:0] y_next;

    // [0],[1] synchroniser stages, [2] edge-detect history
    logic [2:0] gclk_sh;
    logic [2:0] key_sh;
    logic       tick;
    logic       press;
    logic       start;

    always_ff @(posedge newLocClock or negedge RESET_SIM_N) begin
        if (!RESET_SIM_N) begin
            gclk_sh <= '0;
            key_sh  <= '1;
        end else begin
            gclk_sh <= {gclk_sh[1:0], game_clk};
            key_sh  <= {key_sh[1:0], KEY_PAUSE};
        end
    end

    assign tick  = gclk_sh[1] & ~gclk_sh[2];
    assign press = ~key_sh[1] & key_sh[2];

`ifdef SWEEP_SINGLE_STEP_EN
    logic [2:0] step_sh;
    logic       step;

    always_ff @(posedge newLocClock or negedge RESET_SIM_N) begin
        if (!RESET_SIM_N) begin
            step_sh <= '1;
        end else begin
            step_sh <= {step_sh[1:0], STEP_KEY_N};
        end
    end

    assign step  = ~step_sh[1] & step_sh[2];
    assign start = RUN & ((tick & ~paused) | (step & paused));
`else
    assign start = RUN & tick & ~paused;
`endif

    always_ff @(posedge newLocClock or negedge RESET_SIM_N) begin
        if (!RESET_SIM_N) begin
            state      <= S_IDLE;
            writeLoc_x <= '0;
            writeLoc_y <= '0;
            paused     <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_next;
            writeLoc_x <= x_next;
            writeLoc_y <= y_next;
            if (press) begin
                paused <= ~paused;
            end
            if (tick && state != S_IDLE) begin
                overrun <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        x_next     = writeLoc_x;
        y_next     = writeLoc_y;
        view_req   = 1'b0;
        write_flag = 1'b0;
        hold_locs  = 1'b1;
        sweep_busy = 1'b0;
        sweep_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_LOAD;
                    x_next     = '0;
                    y_next     = '0;
                end
            end
            S_LOAD: begin
                sweep_busy = 1'b1;
                view_req   = 1'b1;
                if (view_ack) begin
                    state_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                sweep_busy = 1'b1;
                state_next = S_WRITE;
            end
            S_WRITE: begin
                sweep_busy = 1'b1;
                write_flag = 1'b1;
                state_next = S_ADVANCE;
            end
            S_ADVANCE: begin
                sweep_busy = 1'b1;
                hold_locs  = 1'b0;
                state_next = S_LOAD;
                if (writeLoc_x != X_LAST) begin
                    x_next = writeLoc_x + X_bits'(1);
                end else if (writeLoc_y != Y_LAST) begin
                    x_next = '0;
                    y_next = writeLoc_y + Y_bits'(1);
                end else begin
                    x_next     = '0;
                    y_next     = '0;
                    sweep_done = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        // RUN low aborts any sweep; this overrides the last-cell completion pulse too
        if (state != S_IDLE && !RUN) begin
            state_next = S_IDLE;
            x_next     = '0;
            y_next     = '0;
            sweep_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_grid_sweep_controller.sv
// Scoreboard bench for grid_sweep_controller on a 4x3 grid.
module tb_grid_sweep_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b1;
    logic       game_clk = 1'b0;
    logic       key_pause = 1'b1;
    logic       view_ack = 1'b1;
    logic [7:0] wx;
    logic [7:0] wy;
    logic       view_req, write_flag, hold_locs, sweep_busy, sweep_done, paused, overrun;

    grid_sweep_controller #(.X_bits(8), .Y_bits(8), .X_MAX(4), .Y_MAX(3)) dut (
        .newLocClock(clk),
        .RESET_SIM_N(rst_n),
        .RUN(run),
        .game_clk(game_clk),
        .KEY_PAUSE(key_pause),
        .view_ack(view_ack),
        .writeLoc_x(wx),
        .writeLoc_y(wy),
        .view_req(view_req),
        .write_flag(write_flag),
        .hold_locs(hold_locs),
        .sweep_busy(sweep_busy),
        .sweep_done(sweep_done),
        .paused(paused),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int wr_q[$];
    int done_expected = 0;
    int writes_seen = 0;
    int busy_cycles = 0;
    int cyc = 0;
    int last_write_cyc = 0;
    bit delay_en = 0;
    bit hold_en = 0;
    int ack_cnt = 0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Expected write order for a full 4x3 sweep, encoded as y*16+x
    task automatic push_cells(input int n);
        for (int i = 0; i < n; i++) wr_q.push_back((i / 4) * 16 + (i % 4));
    endtask

    // Monitor: write_flag pops the write queue, sweep_done consumes an expected completion
    logic [7:0] prev_x, prev_y;
    logic       prev_hold = 1'b0, prev_busy = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (sweep_busy) busy_cycles++;
        if (write_flag) begin
            writes_seen++;
            last_write_cyc = cyc;
            if (wr_q.size() == 0) begin
                check("unexpected_write", {16'd0, wy, wx}, -1);
            end else begin
                check("write_coord", int'(wy) * 16 + int'(wx), wr_q.pop_front());
            end
        end
        if (sweep_done) begin
            check("done_expected", done_expected > 0 ? 1 : 0, 1);
            check("done_after_last_write", cyc - last_write_cyc, 1);
            check("done_last_queue_empty", wr_q.size(), 0);
            if (done_expected > 0) done_expected--;
        end
        if (prev_hold && prev_busy && sweep_busy) begin
            check("coords_stable_x", wx, prev_x);
            check("coords_stable_y", wy, prev_y);
        end
        prev_hold = hold_locs;
        prev_busy = sweep_busy;
        prev_x = wx;
        prev_y = wy;
    end

    // view_ack model: optional 5-cycle delay at (1,0), optional indefinite stall at (2,1)
    always @(negedge clk) begin
        if (view_req && delay_en && wx == 8'd1 && wy == 8'd0) begin
            ack_cnt++;
            view_ack = (ack_cnt >= 5);
        end else if (view_req && hold_en && wx == 8'd2 && wy == 8'd1) begin
            view_ack = 1'b0;
        end else begin
            view_ack = 1'b1;
        end
    end

    task automatic do_tick();
        @(negedge clk);
        game_clk = 1'b1;
        repeat (4) @(negedge clk);
        game_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_press();
        @(negedge clk);
        key_pause = 1'b0;
        repeat (4) @(negedge clk);
        key_pause = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (sweep_busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle_timeout"}, sweep_busy, 0);
    endtask

    task automatic wait_writes(input int target);
        int n = 0;
        while (writes_seen < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("wait_writes_timeout", writes_seen >= target ? 1 : 0, 1);
    endtask

    task automatic wait_load_at(input int x, input int y);
        int n = 0;
        while (!(view_req && wx == x[7:0] && wy == y[7:0]) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("wait_load_timeout", n < 400 ? 1 : 0, 1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_view_req"}, view_req, 0);
        check({name, "_write_flag"}, write_flag, 0);
        check({name, "_hold_locs"}, hold_locs, 1);
        check({name, "_busy"}, sweep_busy, 0);
        check({name, "_done"}, sweep_done, 0);
        check({name, "_paused"}, paused, 0);
        check({name, "_overrun"}, overrun, 0);
        check({name, "_x"}, wx, 0);
        check({name, "_y"}, wy, 0);
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Basic sweep: 12 cells x 4 cycles
        push_cells(12);
        done_expected = 1;
        busy_cycles = 0;
        do_tick();
        wait_idle("basic");
        check("basic_busy_cycles", busy_cycles, 48);
        check("basic_writes", writes_seen, 12);
        check("basic_overrun", overrun, 0);

        // Delayed ack at (1,0): view_req held 5 cycles, 4 extra busy cycles
        repeat (3) @(negedge clk);
        delay_en = 1;
        ack_cnt = 0;
        push_cells(12);
        done_expected = 1;
        busy_cycles = 0;
        do_tick();
        wait_idle("delay");
        delay_en = 0;
        check("delay_req_cycles", ack_cnt, 5);
        check("delay_busy_cycles", busy_cycles, 52);

        // Overrun: second tick at write 6
        repeat (3) @(negedge clk);
        base = writes_seen;
        push_cells(12);
        done_expected = 1;
        do_tick();
        wait_writes(base + 6);
        do_tick();
        wait_idle("overrun");
        check("overrun_set", overrun, 1);
        repeat (20) @(negedge clk);
        check("overrun_sticky", overrun, 1);
        check("overrun_no_second_sweep", sweep_busy, 0);
        check("overrun_writes", writes_seen - base, 12);

        // Asynchronous reset while stalled in LOAD at (2,1)
        hold_en = 1;
        base = writes_seen;
        push_cells(6);
        do_tick();
        wait_load_at(2, 1);
        repeat (2) @(negedge clk);
        check("stall_view_req", view_req, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        hold_en = 0;
        check("partial_writes", writes_seen - base, 6);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_reset_idle", sweep_busy, 0);
        check("post_reset_writes", writes_seen - base, 6);

        // Pause pressed mid-sweep: sweep completes, then ticks are ignored
        push_cells(12);
        done_expected = 1;
        do_tick();
        do_press();
        wait_idle("pause");
        check("paused_set", paused, 1);
        base = writes_seen;
        do_tick();
        repeat (20) @(negedge clk);
        check("paused_no_sweep", sweep_busy, 0);
        check("paused_no_writes", writes_seen - base, 0);
        check("paused_no_overrun", overrun, 0);
        do_press();
        check("unpaused", paused, 0);
        push_cells(12);
        done_expected = 1;
        do_tick();
        wait_idle("resume");
        check("resume_writes", writes_seen - base, 12);

        // RUN dropped during SETTLE of (2,1)
        base = writes_seen;
        push_cells(6);
        do_tick();
        wait_load_at(2, 1);
        @(negedge clk);
        check("settle_state", {sweep_busy, view_req, write_flag}, 3'b100);
        run = 1'b0;
        @(negedge clk);
        check("abort_busy", sweep_busy, 0);
        check("abort_x", wx, 0);
        check("abort_y", wy, 0);
        repeat (10) @(negedge clk);
        run = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_writes", writes_seen - base, 6);

        check("final_queue_empty", wr_q.size(), 0);
        check("final_done_pending", done_expected, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/grid_sweep_controller.md
Name: grid_sweep_controller

Overview:
- Sequencer directly upstream of the environment store and env_cache.
- On each game tick it raster-sweeps every grid cell and presents the write coordinates (writeLoc_x/y).
- For each cell it runs a view → settle → write handshake; downstream nextSugar/nextSignal results are committed by the single-cycle write_flag pulse.
- Also owns run/pause gating and overrun detection.

Parameters:
- X_bits, 8, width of x coordinate
- Y_bits, 8, width of y coordinate
- X_MAX, 160, cells per row; legal range 1..2^X_bits
- Y_MAX, 120, rows per sweep; legal range 1..2^Y_bits

Ports:
- newLocClock  in  1  sole clock; all logic on rising edge
- RESET_SIM_N  in  1  asynchronous, active-low reset
- RUN  in  1  level; high = simulation running (setup finished)
- game_clk  in  1  slow game clock from clock_cutter, asynchronous to newLocClock
- KEY_PAUSE  in  1  raw push button, active low
- view_ack  in  1  env_cache has loaded the neighbourhood for the current cell
- writeLoc_x  out  X_bits  current cell x
- writeLoc_y  out  Y_bits  current cell y
- view_req  out  1  request neighbourhood load for current cell
- write_flag  out  1  one-cycle commit strobe for current cell
- hold_locs  out  1  high whenever coordinates must not change (everything except the ADVANCE cycle)
- sweep_busy  out  1  high while a sweep is in progress
- sweep_done  out  1  one-cycle pulse after the last cell's write
- paused  out  1  pause state
- overrun  out  1  sticky; a tick arrived while busy

Behaviour:
- Reset (async assert, sync release): state IDLE, all outputs 0 except hold_locs=1. Coordinates are 0,0.
- Synchronisers:
  - game_clk and KEY_PAUSE each pass through a 2-flop synchroniser plus 1 edge-detect flop.
  - tick = synced game_clk rising edge, seen on the 3rd newLocClock edge after game_clk rises.
  - press = synced KEY_PAUSE falling edge.
- Pause:
  - Each press toggles paused.
  - paused only blocks sweep starts; an in-progress sweep always completes.
- States:
  - IDLE: sweep_busy=0. On tick with RUN=1 and paused=0, go to LOAD with coordinates 0,0. A tick while paused or RUN=0 is discarded (no overrun).
  - LOAD: view_req=1, held until view_ack=1 is sampled, then go to SETTLE. If view_ack is already high on the first LOAD cycle, LOAD lasts exactly 1 cycle. view_req is combinational on state.
  - SETTLE: 1 cycle, view_req=0; gives the next-value logic one cycle of stable cache data.
  - WRITE: write_flag=1 for exactly 1 cycle.
  - ADVANCE: hold_locs=0 for 1 cycle. Coordinates update on exiting ADVANCE:
    - x<X_MAX-1: x+1.
    - x=X_MAX-1, y<Y_MAX-1: x=0, y+1.
    - last cell (X_MAX-1, Y_MAX-1): x=0, y=0, sweep_done=1 for this cycle, next state IDLE.
    - Otherwise next state LOAD.
- sweep_busy: 1 in LOAD/SETTLE/WRITE/ADVANCE.
- Minimum per cell: 4 cycles (LOAD 1, SETTLE 1, WRITE 1, ADVANCE 1).
- Coordinate range: x and y never exceed X_MAX-1 / Y_MAX-1. Comparisons are done at full width with no wrap-through-2^N.
- Overrun: a tick while sweep_busy=1 sets overrun (sticky until reset). The tick is dropped; no queued sweep.
- RUN falling while busy: on the next edge, abort to IDLE. Coordinates clear to 0,0. No write_flag is issued for the partial cell, and sweep_done is not pulsed.
- Simultaneous events:
  - tick and press in the same cycle in IDLE: the tick is evaluated against the pre-toggle paused value.
  - sweep_done and tick in the same cycle: the tick counts as overrun, because busy is still 1 in ADVANCE.

Optional Feature:
- Macro SWEEP_SINGLE_STEP_EN.
- Defined: while paused=1, a press of KEY[1] (extra port STEP_KEY_N, in, 1, active low, synchronised like KEY_PAUSE) starts exactly one full sweep without a tick. That sweep obeys all rules above, including RUN-abort.
- Undefined: the port is absent; paused fully blocks sweeps.

Test Plan:
- Reset mid-LOAD at x=2,y=1 -> all outputs 0, hold_locs=1, coords 0,0 asynchronously; after release, no activity until the next tick.
- X_MAX=4, Y_MAX=3, view_ack tied 1, single tick -> 12 write_flag pulses spaced 4 cycles apart in order (0,0),(1,0)..(3,0),(0,1)..(3,2); sweep_done 1 cycle after the last WRITE; busy for 48 cycles.
- view_ack delayed 5 cycles on cell (1,0) -> view_req high 5 cycles, coords stable, hold_locs=1 throughout, then normal completion.
- Second tick at write 6 of 12 -> overrun=1 and stays 1; sweep still ends after 12 writes; no second sweep starts.
- Press KEY_PAUSE during a sweep -> sweep finishes (12 writes), paused=1, next tick ignored with overrun=0; press again + tick -> sweep runs.
- Drop RUN during cell (2,1) SETTLE -> next cycle IDLE, coords 0,0, no write for (2,1), sweep_done stays 0.
